csa_stream_accumulator: RTL and testbench

//  Sequential multi-operand accumulator: consumes a valid/ready stream of unsigned
//  IN_W-bit operands and keeps the running total in redundant carry-save form (sum, carry).

---
 rtl/csa_stream_accumulator.sv | 78 +++++++
 tb/tb_csa_stream_accumulator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator: carry-save running total per beat,
// one carry-propagate resolve per group, result on a valid/ready port.
module csa_stream_accumulator #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    OUTPUT
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] s;
  logic [ACC_W-1:0] c;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] d;
  logic [ACC_W-1:0] maj;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign d       = {{(ACC_W-IN_W){1'b0}}, in_data};
  assign maj     = (s & c) | (s & d) | (c & d);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      s         <= '0;
      c         <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            s   <= s ^ c ^ d;
            // c is kept weight-aligned; the top carry falls off (mod 2**ACC_W)
            c   <= {maj[ACC_W-2:0], 1'b0};
            cnt <= cnt_inc;
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_sum   <= s + c;
          out_count <= cnt;
          s         <= '0;
          c         <= '0;
          cnt       <= '0;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed table plus hand sequences and random groups for
// csa_stream_accumulator, checked against bench-side expected values.
module tb_csa_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] out_sum;
  logic [15:0] out_count;

  int n_vec = 0;
  int n_err = 0;

  csa_stream_accumulator #(
    .IN_W (32),
    .ACC_W(40),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
    int          reps;
    logic [39:0] es;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] dv, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = dv;
    in_last  = last;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic recv(input string name, input logic [39:0] es,
                      input logic [15:0] ec, input int hold);
    wait_out();
    check({name, "_sum"}, {24'd0, out_sum}, {24'd0, es});
    check({name, "_count"}, {48'd0, out_count}, {48'd0, ec});
    out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check({name, "_hold_sum"}, {24'd0, out_sum}, {24'd0, es});
      check({name, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check({name, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_post_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic send_group(input logic [31:0] base, input logic [31:0] step,
                            input int reps);
    logic [31:0] dv;
    for (int i = 0; i < reps; i++) begin
      dv = base + step * i;
      send_beat(dv, i == reps - 1);
    end
  endtask

  initial begin
    tbl[0] = '{32'd1, 32'd1, 3, 40'd6, 16'd3};
    tbl[1] = '{32'hFFFF_FFFF, 32'd0, 1, 40'h00_FFFF_FFFF, 16'd1};
    tbl[2] = '{32'hFFFF_FFFF, 32'd0, 256, 40'hFF_FFFF_FF00, 16'd256};
    tbl[3] = '{32'hFFFF_FFFF, 32'd0, 257, 40'h00_FFFF_FEFF, 16'd257};
    tbl[4] = '{32'd0, 32'd0, 1, 40'd0, 16'd1};
    tbl[5] = '{32'd10, 32'd10, 4, 40'd100, 16'd4};
    tbl[6] = '{32'h8000_0000, 32'd0, 2, 40'h01_0000_0000, 16'd2};
    tbl[7] = '{32'd1, 32'd0, 65537, 40'h1_0001, 16'hFFFF};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", {24'd0, out_sum}, 64'd0);
    check("rst_out_count", {48'd0, out_count}, 64'd0);

    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b1);
    check("lat_edge1_valid", {63'd0, out_valid}, 64'd0);
    check("lat_edge1_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("lat_edge2_valid", {63'd0, out_valid}, 64'd1);
    recv("lat", 40'd6, 16'd3, 0);

    for (int i = 0; i < 8; i++) begin
      send_group(tbl[i].base, tbl[i].step, tbl[i].reps);
      recv($sformatf("tbl%0d", i), tbl[i].es, tbl[i].ec, 0);
    end

    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b1);
    wait_out();
    in_valid = 1'b1;
    in_data  = 32'd99;
    in_last  = 1'b1;
    recv("stall", 40'd30, 16'd2, 5);
    check("stall_in_ready_back", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    recv("stall_next", 40'd99, 16'd1, 0);

    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    send_beat(32'd5, 1'b0);
    send_beat(32'd7, 1'b1);
    recv("midrst", 40'd12, 16'd2, 0);

    send_beat(32'd4, 1'b1);
    wait_out();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("outrst_valid", {63'd0, out_valid}, 64'd0);
    check("outrst_sum", {24'd0, out_sum}, 64'd0);
    send_beat(32'd3, 1'b1);
    recv("outrst_next", 40'd3, 16'd1, 0);

    for (int g = 0; g < 10; g++) begin
      int          reps;
      logic [39:0] msum;
      logic [31:0] dv;
      reps = $urandom_range(1, 6);
      msum = '0;
      for (int i = 0; i < reps; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        dv   = $urandom;
        msum = msum + {8'd0, dv};
        send_beat(dv, i == reps - 1);
      end
      recv($sformatf("rnd%0d", g), msum, reps[15:0], $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
